// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I execute stage: ALU operations, branch
// conditions (funct3) and operand-forwarding selects.
package rv32i_pkg;

  // ALU operation codes driven on ALUControlE
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  // Branch conditions, encoded as the instruction's funct3
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // Forwarding selects; 2'b11 falls back to the register-file value
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/rv32i_alu.sv
// Purely combinational RV32I ALU. Shift amount is b[4:0]; unused opcodes
// (1011-1111) yield zero. All arithmetic wraps modulo 2^XLEN.
module rv32i_alu
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctrl,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  // Select the operation result for the current opcode
  always_comb begin
    // NOTE: result is defaulted before the case so no opcode path can infer a latch.
    result = '0;
    case (ctrl)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump resolution (combinational redirect to fetch) and the EX/MEM
// pipeline register. Optional macro EXEC_BRANCH_CNT_EN adds branch and
// taken-branch counters as extra outputs.
module execute_cycle
  import rv32i_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RST_PC_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            MemWriteE,
  input  logic            MemReadE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic [3:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RS1_E,
  input  logic [4:0]      RS2_E,
  input  logic [4:0]      RD_E,
  input  logic [2:0]      funct3_E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            MemReadM,
  output logic            ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RD_M,
  output logic [2:0]      funct3_M
`ifdef EXEC_BRANCH_CNT_EN
  ,
  output logic [31:0]     BranchCnt,
  output logic [31:0]     TakenCnt
`endif
);

  // JALR targets must clear bit 0
  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            cond;

  // Source registers only matter to the hazard unit, which taps them upstream
  logic unused_rs;
  assign unused_rs = ^{RS1_E, RS2_E};

  // Forwarding muxes: pick the freshest value of each source operand
  always_comb begin
    src_a = RD1_E;
    fwd_b = RD2_E;
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardBE)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALUResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  rv32i_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a      (src_a),
    .b      (src_b),
    .ctrl   (ALUControlE),
    .result (alu_result)
  );

  // Branch comparator always uses the register operand, never the immediate
  always_comb begin
    cond = 1'b0;
    case (funct3_E)
      BR_EQ:   cond = (src_a == fwd_b);
      BR_NE:   cond = (src_a != fwd_b);
      BR_LT:   cond = ($signed(src_a) <  $signed(fwd_b));
      BR_GE:   cond = ($signed(src_a) >= $signed(fwd_b));
      BR_LTU:  cond = (src_a <  fwd_b);
      BR_GEU:  cond = (src_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  // A jump redirects unconditionally, so it overrides any branch outcome
  assign PCSrcE = (BranchE & cond) | JumpE;

  // Redirect address: register-relative for JALR, PC-relative otherwise
  always_comb begin
    PCTargetE = PCE + Imm_Ext_E;
    if (JumpE && ALUSrcE) begin
      PCTargetE = (src_a + Imm_Ext_E) & ALIGN_MASK;
    end
  end

  // EX/MEM pipeline register; a stall freezes every field
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemReadM   <= 1'b0;
      ResultSrcM <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= RST_PC_VAL;
      RD_M       <= '0;
      funct3_M   <= '0;
    end else if (!StallE) begin
      // NOTE: non-blocking assignments so each flop samples pre-edge values.
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      MemReadM   <= MemReadE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= JumpE ? PCPlus4E : alu_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
      RD_M       <= RD_E;
      funct3_M   <= funct3_E;
    end
  end

`ifdef EXEC_BRANCH_CNT_EN
  // Count branches resolved in unstalled cycles and how many were taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BranchCnt <= '0;
      TakenCnt  <= '0;
    end else if (!StallE && BranchE) begin
      BranchCnt <= BranchCnt + 32'd1;
      if (cond) begin
        TakenCnt <= TakenCnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: a reference model pushes the
// expected EX/MEM contents to a queue when stimulus is driven; each task pops
// and compares once the DUT has clocked. Redirect outputs are checked
// combinationally shortly after the inputs change.
module tb_execute_cycle;
  import rv32i_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0400;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        mr;
    logic        rs;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } m_t;

  logic        clk, rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE, JumpE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RS1_E, RS2_E, RD_E;
  logic [2:0]  funct3_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, MemReadM, ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;
  logic [2:0]  funct3_M;
`ifdef EXEC_BRANCH_CNT_EN
  logic [31:0] BranchCnt, TakenCnt;
`endif

  m_t   exp_q[$];
  m_t   model_m;
  m_t   rst_m;
  int   compared;
  int   mismatched;

  execute_cycle #(
    .XLEN       (32),
    .RST_PC_VAL (RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteE   (RegWriteE),
    .ALUSrcE     (ALUSrcE),
    .MemWriteE   (MemWriteE),
    .MemReadE    (MemReadE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .JumpE       (JumpE),
    .ALUControlE (ALUControlE),
    .RD1_E       (RD1_E),
    .RD2_E       (RD2_E),
    .Imm_Ext_E   (Imm_Ext_E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .RS1_E       (RS1_E),
    .RS2_E       (RS2_E),
    .RD_E        (RD_E),
    .funct3_E    (funct3_E),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .ResultW     (ResultW),
    .StallE      (StallE),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .MemReadM    (MemReadM),
    .ResultSrcM  (ResultSrcM),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M),
    .RD_M        (RD_M),
    .funct3_M    (funct3_M)
`ifdef EXEC_BRANCH_CNT_EN
    ,
    .BranchCnt   (BranchCnt),
    .TakenCnt    (TakenCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic slt_model(input logic [31:0] a, input logic [31:0] b);
    // differing signs: the negative one is smaller; same sign: unsigned order holds
    return (a[31] != b[31]) ? a[31] : (a < b);
  endfunction

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [31:0] r;
    int          sh;
    sh = int'(b[4:0]);
    r  = '0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a + ~b + 32'd1;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << sh;
      4'd6:  r = a >> sh;
      4'd7: begin
        r = a >> sh;
        if (a[31]) for (int i = 0; i < sh; i++) r[31-i] = 1'b1;
      end
      4'd8:  r = {31'd0, slt_model(a, b)};
      4'd9:  r = {31'd0, (a < b)};
      4'd10: r = b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic br_model(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] f3);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return slt_model(a, b);
      3'd5:    return !slt_model(a, b);
      3'd6:    return a < b;
      3'd7:    return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_model(input logic [31:0] rf, input logic [1:0] sel);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return model_m.alu;
    return rf;
  endfunction

  task automatic exp_redirect(output logic src, output logic [31:0] tgt);
    logic [31:0] a, fb;
    a   = fwd_model(RD1_E, ForwardAE);
    fb  = fwd_model(RD2_E, ForwardBE);
    src = JumpE | (BranchE & br_model(a, fb, funct3_E));
    if (JumpE && ALUSrcE) begin
      tgt    = a + Imm_Ext_E;
      tgt[0] = 1'b0;
    end else begin
      tgt = PCE + Imm_Ext_E;
    end
  endtask

  // Compute next EX/MEM contents from current inputs and push the expectation
  task automatic issue();
    m_t          n;
    logic [31:0] a, fb, sb;
    if (!StallE) begin
      a     = fwd_model(RD1_E, ForwardAE);
      fb    = fwd_model(RD2_E, ForwardBE);
      sb    = ALUSrcE ? Imm_Ext_E : fb;
      n.rw  = RegWriteE;
      n.mw  = MemWriteE;
      n.mr  = MemReadE;
      n.rs  = ResultSrcE;
      n.alu = JumpE ? PCPlus4E : alu_model(a, sb, ALUControlE);
      n.wd  = fb;
      n.pc4 = PCPlus4E;
      n.rd  = RD_E;
      n.f3  = funct3_E;
      model_m = n;
    end
    exp_q.push_back(model_m);
  endtask

  function automatic m_t dut_m();
    return {RegWriteM, MemWriteM, MemReadM, ResultSrcM, ALUResultM, WriteDataM,
            PCPlus4M, RD_M, funct3_M};
  endfunction

  // Clock one edge, then fetch DUT state and the oldest expectation
  task automatic advance(output m_t got, output m_t exp);
    @(posedge clk);
    @(negedge clk);
    got = dut_m();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : rst_m;
  endtask

  task automatic set_defaults();
    {RegWriteE, ALUSrcE, MemWriteE, MemReadE, ResultSrcE, BranchE, JumpE} = '0;
    ALUControlE = ALU_ADD;
    RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; PCE = '0; PCPlus4E = '0; ResultW = '0;
    RS1_E = '0; RS2_E = '0; RD_E = '0; funct3_E = '0;
    ForwardAE = FWD_RF; ForwardBE = FWD_RF; StallE = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    m_t got;
    rst = 1'b1;
    set_defaults();
    #1;
    got = dut_m();
    compared++;
    if (got !== rst_m) begin
      mismatched++;
      $display("FAIL reset_initial: got %h required %h", got, rst_m);
    end
    // Reset must dominate a clock edge with live inputs
    RegWriteE = 1'b1; RD1_E = 32'h55; RD_E = 5'd9; PCPlus4E = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    got = dut_m();
    compared++;
    if (got !== rst_m) begin
      mismatched++;
      $display("FAIL reset_held: got %h required %h", got, rst_m);
    end
    rst = 1'b0;
    model_m = rst_m;
    exp_q.delete();
  endtask

  task automatic test_add_forward();
    m_t got, exp;
    set_defaults();
    RD1_E = 32'd7; RegWriteE = 1'b1; RD_E = 5'd3; PCPlus4E = 32'h10;
    issue();
    advance(got, exp);
    compared++;
    if (got !== exp || got.alu !== 32'd7) begin
      mismatched++;
      $display("FAIL add_seed: got %h required %h", got, exp);
    end
    RD1_E = 32'd5; ForwardAE = FWD_MEM; RD2_E = 32'd3; ALUControlE = ALU_ADD;
    issue();
    advance(got, exp);
    compared++;
    if (got !== exp || got.alu !== 32'd10 || got.wd !== 32'd3) begin
      mismatched++;
      $display("FAIL add_fwd_mem: got %h required %h", got, exp);
    end
    // ResultW forwarding on B feeds both the ALU and the store data
    ForwardAE = 2'b11; RD1_E = 32'd100; ForwardBE = FWD_WB; ResultW = 32'h11; RD2_E = 32'd99;
    MemWriteE = 1'b1; funct3_E = 3'b010;
    issue();
    advance(got, exp);
    compared++;
    if (got !== exp || got.alu !== 32'h75 || got.wd !== 32'h11) begin
      mismatched++;
      $display("FAIL add_fwd_wb: got %h required %h", got, exp);
    end
  endtask

  task automatic test_branch();
    logic        es;
    logic [31:0] et;
    logic [31:0] pa[4];
    logic [31:0] pb[4];
    pa = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'd3};
    pb = '{32'd5, 32'd1, 32'hFFFF_FFFF, 32'd7};
    set_defaults();
    StallE = 1'b1;
    BranchE = 1'b1; RD1_E = 32'hFFFF_FFFF; RD2_E = 32'd1; funct3_E = BR_LT;
    PCE = 32'h100; Imm_Ext_E = 32'h20; ALUControlE = ALU_SUB;
    #1;
    compared++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
      mismatched++;
      $display("FAIL blt_signed: got %b/%h required 1/00000120", PCSrcE, PCTargetE);
    end
    funct3_E = BR_LTU;
    #1;
    compared++;
    if (PCSrcE !== 1'b0) begin
      mismatched++;
      $display("FAIL bltu_not_taken: got %b required 0", PCSrcE);
    end
    for (int p = 0; p < 4; p++) begin
      for (int f = 0; f < 8; f++) begin
        // odd pairs route operand A through the write-back forward path
        if (p % 2 == 1) begin
          ForwardAE = FWD_WB; ResultW = pa[p]; RD1_E = ~pa[p];
        end else begin
          ForwardAE = FWD_RF; RD1_E = pa[p];
        end
        RD2_E = pb[p]; funct3_E = 3'(f); ALUSrcE = 1'b1; Imm_Ext_E = 32'h40 + 32'(f);
        #1;
        exp_redirect(es, et);
        compared++;
        if (PCSrcE !== es || PCTargetE !== et) begin
          mismatched++;
          $display("FAIL branch_p%0d_f%0d: got %b/%h required %b/%h", p, f, PCSrcE, PCTargetE, es, et);
        end
      end
    end
    BranchE = 1'b0; funct3_E = BR_EQ; RD1_E = 32'd8; RD2_E = 32'd8; ForwardAE = FWD_RF;
    #1;
    compared++;
    if (PCSrcE !== 1'b0) begin
      mismatched++;
      $display("FAIL no_branch: got %b required 0", PCSrcE);
    end
    StallE = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_jalr();
    m_t got, exp;
    set_defaults();
    JumpE = 1'b1; ALUSrcE = 1'b1; RD1_E = 32'h203; Imm_Ext_E = 32'd4;
    PCE = 32'h40; PCPlus4E = 32'h44; RegWriteE = 1'b1; RD_E = 5'd1;
    #1;
    compared++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h206) begin
      mismatched++;
      $display("FAIL jalr_target: got %b/%h required 1/00000206", PCSrcE, PCTargetE);
    end
    issue();
    advance(got, exp);
    compared++;
    if (got !== exp || got.alu !== 32'h44) begin
      mismatched++;
      $display("FAIL jalr_link: got %h required %h", got, exp);
    end
    // Jump with a false branch condition still redirects, PC-relative
    ALUSrcE = 1'b0; BranchE = 1'b1; funct3_E = BR_EQ; RD1_E = 32'd1; RD2_E = 32'd2;
    PCE = 32'h300; Imm_Ext_E = 32'h10; PCPlus4E = 32'h304;
    #1;
    compared++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h310) begin
      mismatched++;
      $display("FAIL jump_wins: got %b/%h required 1/00000310", PCSrcE, PCTargetE);
    end
    issue();
    advance(got, exp);
    compared++;
    if (got !== exp || got.alu !== 32'h304) begin
      mismatched++;
      $display("FAIL jal_link: got %h required %h", got, exp);
    end
  endtask

  task automatic test_stall();
    m_t got, exp;
    set_defaults();
    RD1_E = 32'd9; RD2_E = 32'd4; ALUControlE = ALU_SUB; RegWriteE = 1'b1;
    RD_E = 5'd7; funct3_E = 3'd2; PCPlus4E = 32'h88;
    issue();
    advance(got, exp);
    compared++;
    if (got !== exp || got.alu !== 32'd5) begin
      mismatched++;
      $display("FAIL stall_load: got %h required %h", got, exp);
    end
    StallE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      RD1_E = $urandom(); RD2_E = $urandom(); ALUControlE = 4'($urandom_range(0, 10));
      RD_E = 5'($urandom()); PCPlus4E = $urandom(); MemReadE = 1'b1;
      issue();
      advance(got, exp);
      compared++;
      if (got !== exp || got.alu !== 32'd5 || got.rd !== 5'd7) begin
        mismatched++;
        $display("FAIL stall_hold_%0d: got %h required %h", c, got, exp);
      end
    end
    StallE = 1'b0;
    RD1_E = 32'd1; RD2_E = 32'd2; ALUControlE = ALU_ADD; RD_E = 5'd12; PCPlus4E = 32'h90;
    issue();
    advance(got, exp);
    compared++;
    if (got !== exp || got.alu !== 32'd3) begin
      mismatched++;
      $display("FAIL stall_release: got %h required %h", got, exp);
    end
  endtask

  task automatic test_async_reset();
    m_t got;
    // EX/MEM now holds non-reset contents from the previous test
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    got = dut_m();
    compared++;
    if (got !== rst_m) begin
      mismatched++;
      $display("FAIL async_reset: got %h required %h", got, rst_m);
    end
    @(negedge clk);
    rst = 1'b0;
    model_m = rst_m;
    exp_q.delete();
  endtask

  task automatic test_shift_invalid();
    m_t got, exp;
    logic [3:0]  ops[7];
    logic [31:0] req[7];
    ops = '{ALU_SRA, 4'b1100, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SLTU, ALU_PASSB};
    req = '{32'hF800_0000, 32'd0, 32'd0, 32'h0800_0000, 32'd1, 32'd0, 32'd4};
    set_defaults();
    RD1_E = 32'h8000_0000; ALUSrcE = 1'b1; Imm_Ext_E = 32'd4;
    for (int i = 0; i < 7; i++) begin
      ALUControlE = ops[i];
      issue();
      advance(got, exp);
      compared++;
      if (got !== exp || got.alu !== req[i]) begin
        mismatched++;
        $display("FAIL alu_op_%b: got %h required %h", ops[i], got.alu, req[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    m_t          got, exp;
    logic        es;
    logic [31:0] et;
    for (int n = 0; n < 60; n++) begin
      RegWriteE = 1'($urandom()); MemWriteE = 1'($urandom()); MemReadE = 1'($urandom());
      ResultSrcE = 1'($urandom()); ALUSrcE = 1'($urandom());
      BranchE = ($urandom_range(0, 2) == 0); JumpE = ($urandom_range(0, 6) == 0);
      ALUControlE = 4'($urandom()); funct3_E = 3'($urandom());
      RD1_E = $urandom();
      RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom();
      Imm_Ext_E = $urandom(); PCE = $urandom(); PCPlus4E = PCE + 32'd4;
      ResultW = $urandom(); RS1_E = 5'($urandom()); RS2_E = 5'($urandom()); RD_E = 5'($urandom());
      ForwardAE = 2'($urandom()); ForwardBE = 2'($urandom());
      StallE = ($urandom_range(0, 3) == 0);
      #1;
      exp_redirect(es, et);
      compared++;
      if (PCSrcE !== es || PCTargetE !== et) begin
        mismatched++;
        $display("FAIL b2b_redirect_%0d: got %b/%h required %b/%h", n, PCSrcE, PCTargetE, es, et);
      end
      issue();
      advance(got, exp);
      compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL b2b_mreg_%0d: got %h required %h", n, got, exp);
      end
    end
    StallE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_m      = '0;
    rst_m.pc4  = RST_PC;
    model_m    = rst_m;
    test_reset();
    test_add_forward();
    test_branch();
    test_jalr();
    test_stall();
    test_async_reset();
    test_shift_invalid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
